// File: rtl/key_debounce_multi_pkg.sv
// Shared types and helpers for the multi-key debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_debounce_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS_W = 2'd1,
    ST_HELD    = 2'd2,
    ST_REL_W   = 2'd3
  } deb_state_t;

  localparam int DEF_N_KEYS       = 4;
  localparam int DEF_DEBOUNCE_CYC = 10;
  localparam int DEF_LONG_CYC     = 1000;
  localparam int DEF_KEY_ACT_LOW  = 1;
  localparam int DEF_LONG_EN      = 1;

  // Width of both counters; must hold the saturated hold count LONG_CYC.
  function automatic int cnt_w(input int long_cyc);
    return $clog2(long_cyc + 1);
  endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pins in, conditioned per-key levels and event pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; events are fire-and-forget pulses.
interface key_debounce_multi_if
  import key_debounce_multi_pkg::*;
#(
  parameter int N_KEYS = DEF_N_KEYS
);
  logic [N_KEYS-1:0] Key;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] sel;

  modport master (
    output Key,
    input  key_level, press_pulse, release_pulse, long_pulse, sel
  );

  modport slave (
    input  Key,
    output key_level, press_pulse, release_pulse, long_pulse, sel
  );
endinterface

// File: rtl/key_debounce_multi_chan.sv
// One key channel: 2-FF sync, press/release debounce FSM, hold counter, registered outputs.
// Latency: press/release pulse DEBOUNCE_CYC+2 edges after the first edge sampling a stable pin.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
module key_debounce_multi_chan
  import key_debounce_multi_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int LONG_EN      = DEF_LONG_EN
) (
  input  logic SYSCLK,
  input  logic RST,
  input  logic k_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic sel
);

  localparam int              CNT_W   = cnt_w(LONG_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] D_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(LONG_CYC);
  localparam bit              ONE_CYC = (DEBOUNCE_CYC == 1);
  localparam bit              LONG_ON = (LONG_EN != 0);

  logic [1:0]       sync_q;
  logic             k_act;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d, lcnt_inc;
  logic             long_done_q, long_done_d;
  logic             level_d, sel_d, press_d, rel_d, long_d;
  logic             long_hit;

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], k_raw};
  end

  assign k_act = sync_q[1];

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      dcnt_q        <= '0;
      lcnt_q        <= '0;
      long_done_q   <= 1'b0;
      key_level     <= 1'b0;
      sel           <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      lcnt_q        <= lcnt_d;
      long_done_q   <= long_done_d;
      key_level     <= level_d;
      sel           <= sel_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      long_pulse    <= long_d;
    end
  end

  assign lcnt_inc = (lcnt_q == L_MAX) ? lcnt_q : lcnt_q + CNT_ONE;
  assign long_hit = LONG_ON && !long_done_q && (lcnt_q == L_LAST);

  // dcnt counts stable cycles already observed, so the cycle that leaves
  // IDLE/HELD is the first one and DEBOUNCE_CYC=1 confirms straight away.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    level_d     = key_level;
    sel_d       = sel;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (k_act) begin
          if (ONE_CYC) begin
            state_d     = ST_HELD;
            press_d     = 1'b1;
            level_d     = 1'b1;
            lcnt_d      = '0;
            long_done_d = 1'b0;
          end else begin
            state_d = ST_PRESS_W;
            dcnt_d  = CNT_ONE;
          end
        end
      end
      ST_PRESS_W: begin
        if (!k_act) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == D_LAST) begin
          state_d     = ST_HELD;
          press_d     = 1'b1;
          level_d     = 1'b1;
          lcnt_d      = '0;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        lcnt_d = lcnt_inc;
        if (!k_act && ONE_CYC) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
          if (!long_done_q) sel_d = ~sel;
        end else begin
          if (long_hit) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
          if (!k_act) begin
            state_d = ST_REL_W;
            dcnt_d  = CNT_ONE;
          end
        end
      end
      ST_REL_W: begin
        lcnt_d = lcnt_inc;
        // A release confirming on the same cycle the hold limit is reached counts as short.
        if (!k_act && (dcnt_q == D_LAST)) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
          if (!long_done_q) sel_d = ~sel;
        end else begin
          if (long_hit) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
          if (k_act) state_d = ST_HELD;
          else       dcnt_d  = dcnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/key_debounce_multi.sv
// N independent key conditioners with pin polarity normalised to 1 = pressed.
// Latency: DEBOUNCE_CYC+2 SYSCLK edges from first stable pin sample to press/release pulse.
// Backpressure: none; all outputs are registered pulses/levels.
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int N_KEYS       = DEF_N_KEYS,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int KEY_ACT_LOW  = DEF_KEY_ACT_LOW,
  parameter int LONG_EN      = DEF_LONG_EN
) (
  input  logic                 SYSCLK,
  input  logic                 RST,
  key_debounce_multi_if.slave  kif
);

  localparam bit INV = (KEY_ACT_LOW != 0);

  logic [N_KEYS-1:0] k_raw;
  logic [N_KEYS-1:0] level_w, press_w, rel_w, long_w, sel_w;

  assign k_raw = kif.Key ^ {N_KEYS{INV}};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_multi_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .LONG_EN      (LONG_EN)
    ) u_chan (
      .SYSCLK        (SYSCLK),
      .RST           (RST),
      .k_raw         (k_raw[g]),
      .key_level     (level_w[g]),
      .press_pulse   (press_w[g]),
      .release_pulse (rel_w[g]),
      .long_pulse    (long_w[g]),
      .sel           (sel_w[g])
    );
  end

  assign kif.key_level     = level_w;
  assign kif.press_pulse   = press_w;
  assign kif.release_pulse = rel_w;
  assign kif.long_pulse    = long_w;
  assign kif.sel           = sel_w;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: expected pulse events queued at drive time, popped on output.
// A second single-key instance with long-press detection disabled checks the toggle-only behaviour.
module tb_key_debounce_multi;

  logic SYSCLK;
  logic RST;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n2_press = 0;
  int   n2_rel = 0;
  int   n2_long = 0;
  logic [3:0] sel_exp;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
  } ev_t;
  ev_t q[$];

  key_debounce_multi_if #(.N_KEYS(4)) kif ();
  key_debounce_multi_if #(.N_KEYS(1)) kif2 ();

  key_debounce_multi #(
    .N_KEYS(4), .DEBOUNCE_CYC(10), .LONG_CYC(100), .KEY_ACT_LOW(1), .LONG_EN(1)
  ) dut (
    .SYSCLK (SYSCLK),
    .RST    (RST),
    .kif    (kif)
  );

  key_debounce_multi #(
    .N_KEYS(1), .DEBOUNCE_CYC(10), .LONG_CYC(100), .KEY_ACT_LOW(1), .LONG_EN(0)
  ) dut_nolong (
    .SYSCLK (SYSCLK),
    .RST    (RST),
    .kif    (kif2)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  always @(posedge SYSCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = c;
    e.p   = p;
    e.r   = r;
    e.l   = l;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  // Scoreboard: every cycle with any pulse must match the oldest queued event.
  always @(negedge SYSCLK) begin
    if ((kif.press_pulse | kif.release_pulse | kif.long_pulse) != 4'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'({kif.press_pulse, kif.release_pulse, kif.long_pulse}), 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_vec", 32'({kif.press_pulse, kif.release_pulse, kif.long_pulse}),
            32'({e.p, e.r, e.l}));
      end
    end
  end

  always @(negedge SYSCLK) begin
    if (kif2.press_pulse[0])   n2_press++;
    if (kif2.release_pulse[0]) n2_rel++;
    if (kif2.long_pulse[0])    n2_long++;
  end

  initial begin
    kif.Key  = 4'hF;
    kif2.Key = 1'b1;
    sel_exp  = 4'b0;
    RST      = 1'b1;
    tick(3);
    chk("reset_outs", 32'({kif.key_level, kif.press_pulse, kif.release_pulse, kif.long_pulse, kif.sel}), 32'd0);
    RST = 1'b0;
    tick(5);
    chk("idle_outs", 32'({kif.key_level, kif.sel}), 32'd0);

    // Clean press on key 0 held 30 cycles.
    kif.Key[0] = 1'b0;
    expect_ev(cyc + 12, 4'b0001, 4'b0000, 4'b0000);
    tick(20);
    chk("clean_level", 32'(kif.key_level), 32'h1);
    tick(10);
    kif.Key[0] = 1'b1;
    expect_ev(cyc + 12, 4'b0000, 4'b0001, 4'b0000);
    sel_exp[0] = ~sel_exp[0];
    tick(15);
    chk("clean_sel", 32'(kif.sel), 32'(sel_exp));
    chk("clean_level_rel", 32'(kif.key_level), 32'h0);

    // 9-cycle glitch must not confirm; exactly 10 cycles must.
    kif.Key[0] = 1'b0;
    tick(9);
    kif.Key[0] = 1'b1;
    tick(15);
    chk("glitch9_sel", 32'(kif.sel), 32'(sel_exp));
    kif.Key[0] = 1'b0;
    expect_ev(cyc + 12, 4'b0001, 4'b0000, 4'b0000);
    tick(10);
    kif.Key[0] = 1'b1;
    expect_ev(cyc + 12, 4'b0000, 4'b0001, 4'b0000);
    sel_exp[0] = ~sel_exp[0];
    tick(15);
    chk("min10_sel", 32'(kif.sel), 32'(sel_exp));

    // Key 1 bounces every 3 cycles, then settles low.
    for (int i = 0; i < 6; i++) begin
      kif.Key[1] = ~kif.Key[1];
      tick(3);
    end
    kif.Key[1] = 1'b0;
    expect_ev(cyc + 12, 4'b0010, 4'b0000, 4'b0000);
    tick(30);
    kif.Key[1] = 1'b1;
    expect_ev(cyc + 12, 4'b0000, 4'b0010, 4'b0000);
    sel_exp[1] = ~sel_exp[1];
    tick(15);
    chk("bounce_sel", 32'(kif.sel), 32'(sel_exp));

    // Long press on key 2 (and on the long-disabled instance).
    kif.Key[2] = 1'b0;
    kif2.Key   = 1'b0;
    expect_ev(cyc + 12, 4'b0100, 4'b0000, 4'b0000);
    expect_ev(cyc + 112, 4'b0000, 4'b0000, 4'b0100);
    tick(150);
    chk("long_level", 32'(kif.key_level), 32'h4);
    kif.Key[2] = 1'b1;
    kif2.Key   = 1'b1;
    expect_ev(cyc + 12, 4'b0000, 4'b0100, 4'b0000);
    tick(15);
    chk("long_sel", 32'(kif.sel), 32'(sel_exp));
    chk("nolong_press", n2_press, 1);
    chk("nolong_long", n2_long, 0);
    chk("nolong_rel", n2_rel, 1);
    chk("nolong_sel", 32'(kif2.sel), 32'h1);

    // All four keys pressed and released in the same cycle.
    kif.Key = 4'b0000;
    expect_ev(cyc + 12, 4'b1111, 4'b0000, 4'b0000);
    tick(30);
    chk("sim_level", 32'(kif.key_level), 32'hF);
    kif.Key = 4'b1111;
    expect_ev(cyc + 12, 4'b0000, 4'b1111, 4'b0000);
    sel_exp = ~sel_exp;
    tick(15);
    chk("sim_sel", 32'(kif.sel), 32'(sel_exp));

    // Reset while key 0 is held, then a fresh press after reset release.
    kif.Key[0] = 1'b0;
    expect_ev(cyc + 12, 4'b0001, 4'b0000, 4'b0000);
    tick(50);
    chk("pre_rst_level", 32'(kif.key_level), 32'h1);
    RST = 1'b1;
    #1;
    chk("async_rst_outs", 32'({kif.key_level, kif.press_pulse, kif.release_pulse, kif.long_pulse, kif.sel}), 32'd0);
    sel_exp = 4'b0;
    tick(3);
    RST = 1'b0;
    expect_ev(cyc + 12, 4'b0001, 4'b0000, 4'b0000);
    tick(20);
    chk("post_rst_level", 32'(kif.key_level), 32'h1);
    kif.Key[0] = 1'b1;
    expect_ev(cyc + 12, 4'b0000, 4'b0001, 4'b0000);
    sel_exp[0] = ~sel_exp[0];
    tick(15);
    chk("post_rst_sel", 32'(kif.sel), 32'(sel_exp));

    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
